gpio_shift_out: RTL and testbench
=================================

# gpio_shift_out

Serializer stage directly downstream of the GPIO output latch. It watches the latch's 8-bit parallel output and, whenever that value changes, shifts it MSB-first into an external 74HC595-style shift/storage register chain over SCK/SDO/RCK. The CPU only writes the latch. This block makes the serial expander track the latch automatically and reports transfer activity on BUSY.

## Interface
- CLK_DIV, 4, system clocks per SCK half-period and per RCK pulse; legal range 1..255
- WIDTH, 8, bits per transfer; must match the latch width
- CLK  in  1  system clock; all state changes on rising edge
- RST  in  1  reset, asynchronous and active-high
- DATA  in  WIDTH  parallel value from the GPIO output latch
- FORCE  in  1  single-cycle request to resend DATA even when unchanged
- SDI  in  1  serial readback input; used only with the readback feature
- SCK  out  1  serial clock; the external register samples on the rising edge
- SDO  out  1  serial data, MSB first
- RCK  out  1  storage-register latch pulse, active-high
- BUSY  out  1  high while a transfer is in progress
- DIN  out  WIDTH  last captured readback word

## Operation
- Reset values:
  - SCK, SDO, RCK and BUSY are 0.
  - DIN is 0.
  - The state is IDLE.
  - SENT (shadow of the last value transferred) is 0.
  - PEND is 1, so the first transfer after reset is guaranteed.
- State machine:
  - IDLE → SHIFT when (DATA != SENT) or FORCE or PEND.
    - On that edge: SHREG ← DATA, SENT ← DATA, PEND ← 0, BUSY ← 1, bit counter ← 0.
  - SHIFT, per bit:
    - SDO = SHREG[WIDTH-1] and SCK = 0 for CLK_DIV cycles.
    - Then SCK = 1 for CLK_DIV cycles.
    - On the falling SCK step, SHREG shifts left and the counter increments.
    - After bit WIDTH-1 completes, the state goes to LATCH.
  - LATCH: SCK = 0, SDO = 0, RCK = 1 for CLK_DIV cycles, then → IDLE with BUSY ← 0.
- Changes to DATA during SHIFT or LATCH are not sampled. On return to IDLE, DATA is compared against SENT, and any difference starts a new transfer on the next edge. Intermediate values may be skipped; the final value is always sent.
- A FORCE pulse during a transfer sets PEND, which causes exactly one extra transfer afterwards.
- Reset asserted mid-transfer aborts the transfer immediately:
  - All outputs go to their reset values.
  - PEND = 1, so a full transfer of current DATA follows reset release.
- The bit counter must never exceed WIDTH-1. The CLK_DIV counter wraps to 0 at each phase boundary.

## Timing
- Start latency: a change in DATA in IDLE causes BUSY = 1 and SDO = DATA[WIDTH-1] one cycle later.
- BUSY high time is exactly (2·WIDTH + 1)·CLK_DIV cycles. For WIDTH = 8 and CLK_DIV = 4 this is 68 cycles.
- The first SCK rise occurs CLK_DIV cycles after BUSY rises.
- SDO is stable for CLK_DIV cycles before each SCK rise and for CLK_DIV cycles after it.
- RCK rises CLK_DIV cycles after the last SCK rise.
- Back-to-back transfers: the minimum BUSY-low gap is 1 cycle.

## Configuration
- GPIO_SHIFT_READBACK_EN defined:
  - SDI is sampled on the cycle of each SCK rise and shifted into an input register, MSB first.
  - DIN is loaded from that register on entry to LATCH.
- Not defined:
  - SDI is ignored.
  - DIN is held at 0.
  - No input shift register is instantiated.
- The port list is identical in both builds.

## Structure
- Package gpio_shift_pkg contains:
  - the state enum (ST_IDLE, ST_SHIFT, ST_LATCH);
  - the default WIDTH constant;
  - the bit-counter width derived from WIDTH.
- One sub-module, gpio_tick_div: a CLK_DIV phase counter that emits a one-cycle tick at each phase end. It clears while the state is IDLE.

## Test plan
- Reset release with DATA = 8'h00 → one 68-cycle transfer; SDO stream is 0×8; one RCK pulse of 4 cycles.
- DATA 8'h00 → 8'hA5 in IDLE → BUSY rises next cycle; bits sampled at SCK rises are 1,0,1,0,0,1,0,1; RCK pulses once; SENT = A5.
- DATA stepped A5 → 3C → C3 during a transfer → the current transfer completes, then exactly one transfer of C3; 3C is never sent.
- FORCE pulse with DATA == SENT = 8'h5A → one transfer of 5A. A second FORCE during that transfer → exactly one more transfer.
- RST asserted at bit 3 of a transfer → SCK, SDO, RCK and BUSY go to 0 immediately. After release, a full transfer of current DATA follows.
- With GPIO_SHIFT_READBACK_EN, SDI driven with 8'h96 aligned to SCK rises → DIN = 8'h96 on LATCH entry. Without the macro → DIN stays 8'h00.

Source files
------------

// File: rtl/gpio_shift_pkg.sv
// Shared types and sizing helpers for the GPIO latch serializer.
package gpio_shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 8;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned BIT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/gpio_tick_div.sv
// Phase divider: emits a one-cycle tick at the end of every CLK_DIV-cycle phase.
module gpio_tick_div
    import gpio_shift_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned            DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0]       LAST  = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i || (cnt_q == LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/gpio_shift_out.sv
// Tracks the GPIO latch and mirrors it into a 74HC595-style chain over SCK/SDO/RCK.
// Optional SDI readback into DIN is enabled by defining GPIO_SHIFT_READBACK_EN.
module gpio_shift_out
    import gpio_shift_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned WIDTH   = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             force_i,
    input  logic             sdi_i,
    output logic             sck_o,
    output logic             sdo_o,
    output logic             rck_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] din_o
);

    localparam int unsigned      BIT_W    = cnt_width(WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] sent_q;
    logic             pend_q;
    logic [BIT_W-1:0] bit_q;
    logic             sck_q;
    logic             rck_q;
    logic             busy_q;
    logic             tick;
    logic             div_clear;

`ifdef GPIO_SHIFT_READBACK_EN
    logic [WIDTH-1:0] in_q;
    logic [WIDTH-1:0] din_q;
`endif

    assign div_clear = (state_q == ST_IDLE);

    gpio_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_div (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (div_clear),
        .tick_o  (tick)
    );

    // SCK doubles as the bit phase flag; the shift register drains to zero so SDO idles low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            sent_q  <= '0;
            pend_q  <= 1'b1;
            bit_q   <= '0;
            sck_q   <= 1'b0;
            rck_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef GPIO_SHIFT_READBACK_EN
            in_q    <= '0;
            din_q   <= '0;
`endif
        end else begin
            if (force_i && (state_q != ST_IDLE)) begin
                pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if ((data_i != sent_q) || force_i || pend_q) begin
                        state_q <= ST_SHIFT;
                        shreg_q <= data_i;
                        sent_q  <= data_i;
                        pend_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                        sck_q   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!sck_q) begin
                            sck_q <= 1'b1;
`ifdef GPIO_SHIFT_READBACK_EN
                            in_q  <= {in_q[WIDTH-2:0], sdi_i};
`endif
                        end else begin
                            sck_q   <= 1'b0;
                            shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
                            if (bit_q == LAST_BIT) begin
                                state_q <= ST_LATCH;
                                rck_q   <= 1'b1;
`ifdef GPIO_SHIFT_READBACK_EN
                                din_q   <= in_q;
`endif
                            end else begin
                                bit_q <= bit_q + 1'b1;
                            end
                        end
                    end
                end
                ST_LATCH: begin
                    if (tick) begin
                        state_q <= ST_IDLE;
                        rck_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign sck_o  = sck_q;
    assign sdo_o  = shreg_q[WIDTH-1];
    assign rck_o  = rck_q;
    assign busy_o = busy_q;

`ifdef GPIO_SHIFT_READBACK_EN
    assign din_o = din_q;
`else
    logic unused_sdi;
    assign unused_sdi = sdi_i;
    assign din_o      = '0;
`endif

endmodule

// File: tb/tb_gpio_shift_out.sv
// Self-checking bench for gpio_shift_out: directed steps plus randomized latch traffic.
module tb_gpio_shift_out;

    localparam int CLK_DIV = 4;
    localparam int WIDTH   = 8;
    localparam int XFER    = (2 * WIDTH + 1) * CLK_DIV;

`ifdef GPIO_SHIFT_READBACK_EN
    localparam logic [7:0] RB_EXP = 8'h96;
`else
    localparam logic [7:0] RB_EXP = 8'h00;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dataIn = 8'h00;
    logic       forceIn = 1'b0;
    logic       sdiIn = 1'b0;
    logic       sck, sdo, rck, busy;
    logic [7:0] din;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] word;
        int         bits;
        int         busyCycles;
        int         rckCycles;
        logic       shapeOk;
    } xfer_t;

    xfer_t      rxQ[$];
    logic [7:0] expQ[$];

    gpio_shift_out #(
        .CLK_DIV (CLK_DIV),
        .WIDTH   (WIDTH)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .data_i  (dataIn),
        .force_i (forceIn),
        .sdi_i   (sdiIn),
        .sck_o   (sck),
        .sdo_o   (sdo),
        .rck_o   (rck),
        .busy_o  (busy),
        .din_o   (din)
    );

    always #5 clk = ~clk;

    // Observes the serial pins like the external '595 would and logs each finished transfer.
    initial begin
        logic       pSck, pRck, pBusy, pSdo, curShape;
        logic [7:0] curWord;
        int         curBits, curBusy, curRck, sckRun;
        pSck = 0; pRck = 0; pBusy = 0; pSdo = 0; curShape = 1;
        curWord = 0; curBits = 0; curBusy = 0; curRck = 0; sckRun = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pSck = 0; pRck = 0; pBusy = 0; pSdo = 0; curShape = 1;
                curWord = 0; curBits = 0; curBusy = 0; curRck = 0; sckRun = 0;
            end else begin
                if (busy && !pBusy) begin
                    curWord = 0; curBits = 0; curBusy = 0; curRck = 0; sckRun = 0; curShape = 1;
                end
                if (busy) begin
                    curBusy++;
                    if (rck) curRck++;
                    if (pBusy && (sck != pSck)) begin
                        if (sckRun != CLK_DIV) curShape = 0;
                        sckRun = 1;
                    end else begin
                        sckRun++;
                    end
                    if (sck && !pSck) begin
                        curWord = {curWord[6:0], sdo};
                        curBits++;
                        if (sdo !== pSdo) curShape = 0;
                    end
                    if (rck && !pRck && !(pSck && !sck)) curShape = 0;
                end
                if (!busy && pBusy) begin
                    rxQ.push_back('{curWord, curBits, curBusy, curRck, curShape});
                end
                pSck = sck; pRck = rck; pBusy = busy; pSdo = sdo;
            end
        end
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic pulseForce();
        forceIn = 1'b1;
        step(1);
        forceIn = 1'b0;
    endtask

    // Changes the latch value in IDLE and checks the one-cycle start latency.
    task automatic startAndCheck(input logic [7:0] value);
        dataIn = value;
        @(posedge clk);
        @(negedge clk);
        checkEq("startBusy", busy, 1);
        checkEq("startSdo", sdo, value[7]);
    endtask

    task automatic checkTransfers(input string tag);
        int n;
        checkEq({tag, ".count"}, rxQ.size(), expQ.size());
        n = (rxQ.size() < expQ.size()) ? rxQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkEq({tag, ".word"}, rxQ[i].word, expQ[i]);
            checkEq({tag, ".bits"}, rxQ[i].bits, WIDTH);
            checkEq({tag, ".busyLen"}, rxQ[i].busyCycles, XFER);
            checkEq({tag, ".rckLen"}, rxQ[i].rckCycles, CLK_DIV);
            checkEq({tag, ".shape"}, rxQ[i].shapeOk, 1);
        end
        rxQ.delete();
        expQ.delete();
    endtask

    task automatic driveReadback(input logic [7:0] pattern);
        int   n;
        logic timedOut;
        timedOut = 0;
        for (int i = 0; i < 8; i++) begin
            sdiIn = pattern[7 - i];
            n = 0;
            while (sck !== 1'b1 && n < 40) begin @(negedge clk); n++; end
            if (n >= 40) timedOut = 1;
            n = 0;
            while (sck !== 1'b0 && n < 40) begin @(negedge clk); n++; end
            if (n >= 40) timedOut = 1;
        end
        n = 0;
        while (rck !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) timedOut = 1;
        checkEq("rbTimeout", timedOut, 0);
        checkEq("dinAtLatch", din, RB_EXP);
    endtask

    initial begin
        logic [7:0] lastSent, v, w;
        logic       forced;
        int         nInter;

        // Reset state and the guaranteed first transfer.
        step(3);
        checkEq("rstSck", sck, 0);
        checkEq("rstSdo", sdo, 0);
        checkEq("rstRck", rck, 0);
        checkEq("rstBusy", busy, 0);
        checkEq("rstDin", din, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkEq("firstBusy", busy, 1);
        step(200);
        expQ.push_back(8'h00);
        checkTransfers("first");

        // Plain change in IDLE.
        startAndCheck(8'hA5);
        step(200);
        expQ.push_back(8'hA5);
        checkTransfers("a5");

        // Resend A5 via FORCE while stepping DATA; only the final value follows.
        pulseForce();
        step(10);
        dataIn = 8'h3C;
        step(15);
        dataIn = 8'hC3;
        step(200);
        expQ.push_back(8'hA5);
        expQ.push_back(8'hC3);
        checkTransfers("skip");

        // FORCE with unchanged data, then a second FORCE mid-transfer.
        startAndCheck(8'h5A);
        step(200);
        expQ.push_back(8'h5A);
        checkTransfers("5a");
        pulseForce();
        step(200);
        expQ.push_back(8'h5A);
        checkTransfers("force1");
        pulseForce();
        step(20);
        pulseForce();
        step(200);
        expQ.push_back(8'h5A);
        expQ.push_back(8'h5A);
        checkTransfers("force2");

        // Reset during bit 3 aborts, then the current DATA is resent.
        startAndCheck(8'h99);
        step(29);
        checkEq("preRstSck", sck, 1);
        checkEq("preRstBusy", busy, 1);
        rst = 1'b1;
        #1;
        checkEq("abortSck", sck, 0);
        checkEq("abortSdo", sdo, 0);
        checkEq("abortRck", rck, 0);
        checkEq("abortBusy", busy, 0);
        step(3);
        rst = 1'b0;
        step(200);
        expQ.push_back(8'h99);
        checkTransfers("abort");

        // Readback word aligned to SCK rises.
        startAndCheck(8'h66);
        driveReadback(8'h96);
        step(200);
        checkEq("dinHold", din, RB_EXP);
        expQ.push_back(8'h66);
        checkTransfers("readback");
        lastSent = 8'h66;

        // Random traffic: one transfer of the first value, then one of the final value
        // if it differs from what was sent or a FORCE arrived meanwhile.
        for (int it = 0; it < 8; it++) begin
            v = lastSent ^ 8'($urandom_range(1, 255));
            startAndCheck(v);
            nInter = $urandom_range(0, 2);
            for (int k = 0; k < nInter; k++) begin
                step($urandom_range(3, 12));
                dataIn = 8'($urandom_range(0, 255));
            end
            step($urandom_range(3, 12));
            w = ($urandom_range(0, 3) == 0) ? v : 8'($urandom_range(0, 255));
            dataIn = w;
            forced = 1'($urandom_range(0, 1));
            if (forced) begin
                step(2);
                pulseForce();
            end
            step(200);
            expQ.push_back(v);
            if ((w != v) || forced) expQ.push_back(w);
            checkTransfers("rand");
            lastSent = w;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
